// File: rtl/bombe_search_ctrl.sv
// bombe_search_ctrl: buffers a ciphertext and sweeps every distinct rotor order
// and start position across lock-stepped external enigma lanes. Lanes whose
// output window matches the crib are queued in a valid/ready hit FIFO.
module bombe_search_ctrl #(
  parameter int CRIB_LEN       = 5,
  parameter int NUM_LANES      = 32,
  parameter int MSG_DEPTH      = 1024,
  parameter int NUM_ROTORS     = 5,
  parameter int HIT_FIFO_DEPTH = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [4:0]                   msg_letter_in,
  input  logic                         msg_valid_in,
  input  logic                         msg_last_in,
  input  logic [CRIB_LEN*5-1:0]        crib_in,
  input  logic [$clog2(MSG_DEPTH)-1:0] crib_offset_in,
  output logic                         lane_start_out,
  output logic [8:0]                   lane_order_out,
  output logic [14:0]                  lane_pos_base_out,
  output logic [4:0]                   lane_letter_out,
  output logic                         lane_letter_valid_out,
  input  logic [NUM_LANES*5-1:0]       lane_result_in,
  input  logic                         lane_result_valid_in,
  output logic                         hit_valid_out,
  input  logic                         hit_ready_in,
  output logic [8:0]                   hit_order_out,
  output logic [14:0]                  hit_pos_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         error_out
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int IW = AW + 2;
  localparam int KW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int FW = (HIT_FIFO_DEPTH > 1) ? $clog2(HIT_FIFO_DEPTH) : 1;
  localparam logic [IW-1:0] DEPTH_I   = IW'(MSG_DEPTH);
  localparam logic [IW-1:0] CRIB_I    = IW'(CRIB_LEN);
  localparam logic [5:0]    LANES6    = 6'(NUM_LANES);
  localparam logic [KW-1:0] LAST_LANE = KW'(NUM_LANES - 1);
  localparam logic [FW:0]   FIFO_FULL = (FW + 1)'(HIT_FIFO_DEPTH);
  localparam logic [2:0]    RMAX      = 3'(NUM_ROTORS - 1);
  localparam logic [2:0]    RMAX1     = 3'(NUM_ROTORS - 2);
  localparam logic [2:0]    RMAX2     = 3'(NUM_ROTORS - 3);

  typedef enum logic [3:0] {
    S_LOAD, S_START, S_FEED_RD, S_FEED_STB, S_WAIT, S_SCAN, S_NEXT, S_ORDER, S_DONE
  } state_t;

  state_t                state_q;
  logic [4:0]            msgMem_q [MSG_DEPTH];
  logic [4:0]            rdData_q;
  logic [IW-1:0]         wrPtr_q, idx_q;
  logic [AW-1:0]         offset_q;
  logic [CRIB_LEN*5-1:0] crib_q;
  logic [NUM_LANES-1:0]  match_q;
  logic [KW-1:0]         lane_q;
  logic [2:0]            r1_q, r2_q, r3_q;
  logic [4:0]            p1_q, p2_q, base_q;
  logic                  laneStart_q, letterValid_q, busy_q, done_q, error_q;
  logic [23:0]           fifoMem_q [HIT_FIFO_DEPTH];
  logic [FW-1:0]         fifoWr_q, fifoRd_q;
  logic [FW:0]           fifoCount_q;

  logic          writeOk, dropLetter, inWindow, lastLetter, laneValid, laneHit;
  logic          scanPush, scanStall, baseWrap, orderLast, orderDistinct;
  logic          hitPop, fifoFull, fifoEmpty;
  logic [IW-1:0] lenNow, needEnd;
  logic [4:0]    cribLetter;
  logic [5:0]    laneSum, baseNext;

  assign writeOk       = (state_q == S_LOAD) && msg_valid_in && (wrPtr_q < DEPTH_I);
  assign dropLetter    = (state_q == S_LOAD) && msg_valid_in && !(wrPtr_q < DEPTH_I);
  assign lenNow        = wrPtr_q + IW'(writeOk);
  assign needEnd       = IW'(crib_offset_in) + CRIB_I;
  assign lastLetter    = (idx_q == IW'(offset_q) + CRIB_I - IW'(1));
  assign laneSum       = 6'(base_q) + 6'(lane_q);
  assign laneValid     = (laneSum <= 6'd25);
  assign laneHit       = match_q[lane_q] && laneValid;
  assign fifoFull      = (fifoCount_q == FIFO_FULL);
  assign fifoEmpty     = (fifoCount_q == '0);
  assign hitPop        = !fifoEmpty && hit_ready_in;
  assign scanPush      = (state_q == S_SCAN) && laneHit && (!fifoFull || hitPop);
  assign scanStall     = (state_q == S_SCAN) && laneHit && fifoFull && !hitPop;
  assign baseNext      = 6'(base_q) + LANES6;
  assign baseWrap      = (baseNext > 6'd25);
  assign orderLast     = (r1_q == RMAX) && (r2_q == RMAX1) && (r3_q == RMAX2);
  assign orderDistinct = (r1_q != r2_q) && (r1_q != r3_q) && (r2_q != r3_q);

  assign lane_start_out        = laneStart_q;
  assign lane_order_out        = {r1_q, r2_q, r3_q};
  assign lane_pos_base_out     = {p1_q, p2_q, base_q};
  assign lane_letter_out       = letterValid_q ? rdData_q : 5'd0;
  assign lane_letter_valid_out = letterValid_q;
  assign hit_valid_out         = !fifoEmpty;
  assign {hit_order_out, hit_pos_out} = fifoEmpty ? 24'd0 : fifoMem_q[fifoRd_q];
  assign busy_out              = busy_q;
  assign done_out              = done_q;
  assign error_out             = error_q;

  // Raw lexicographic step of the rotor triple; repeated triples are skipped by the caller.
  function automatic logic [8:0] stepOrder(input logic [2:0] a, input logic [2:0] b,
                                           input logic [2:0] c);
    if (c != RMAX)      return {a, b, c + 3'd1};
    else if (b != RMAX) return {a, b + 3'd1, 3'd0};
    else                return {a + 3'd1, 3'd0, 3'd0};
  endfunction

  // Select the crib letter the current message index must match, if any.
  always_comb begin
    inWindow   = 1'b0;
    cribLetter = 5'd0;
    for (int c = 0; c < CRIB_LEN; c++) begin
      if (idx_q == IW'(offset_q) + IW'(c)) begin
        inWindow   = 1'b1;
        cribLetter = crib_q[c*5 +: 5];
      end
    end
  end

  // Ciphertext buffer: writes while loading, one-cycle registered read for feeding.
  always_ff @(posedge clk_in) begin
    if (writeOk && !rst_in) msgMem_q[wrPtr_q[AW-1:0]] <= msg_letter_in;
    rdData_q <= msgMem_q[idx_q[AW-1:0]];
  end

  // Search sequencer: load, then start/feed/wait/scan/next per setting until done.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_LOAD;
      wrPtr_q <= '0; idx_q <= '0; offset_q <= '0; crib_q <= '0;
      match_q <= '0; lane_q <= '0;
      r1_q <= '0; r2_q <= '0; r3_q <= '0; p1_q <= '0; p2_q <= '0; base_q <= '0;
      laneStart_q <= 1'b0; letterValid_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
    end else begin
      laneStart_q   <= 1'b0;
      letterValid_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (writeOk) wrPtr_q <= wrPtr_q + IW'(1);
          if (dropLetter) error_q <= 1'b1;
          if (msg_last_in) begin
            offset_q <= crib_offset_in;
            crib_q   <= crib_in;
            r1_q <= 3'd0; r2_q <= 3'd1; r3_q <= 3'd2;
            p1_q <= '0; p2_q <= '0; base_q <= '0;
            if (needEnd > lenNow) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              laneStart_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_START;
            end
          end
        end
        S_START: begin
          idx_q   <= '0;
          match_q <= '1;
          state_q <= S_FEED_RD;
        end
        S_FEED_RD: begin
          letterValid_q <= 1'b1;
          state_q       <= S_FEED_STB;
        end
        S_FEED_STB: state_q <= S_WAIT;
        S_WAIT: begin
          if (lane_result_valid_in) begin
            if (inWindow) begin
              for (int k = 0; k < NUM_LANES; k++) begin
                if (lane_result_in[k*5 +: 5] != cribLetter) match_q[k] <= 1'b0;
              end
            end
            if (lastLetter) begin
              lane_q  <= '0;
              state_q <= S_SCAN;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= S_FEED_RD;
            end
          end
        end
        S_SCAN: begin
          if (!scanStall) begin
            if (lane_q == LAST_LANE) state_q <= S_NEXT;
            else                     lane_q  <= lane_q + KW'(1);
          end
        end
        S_NEXT: begin
          if (!baseWrap) begin
            base_q      <= baseNext[4:0];
            laneStart_q <= 1'b1;
            state_q     <= S_START;
          end else begin
            base_q <= '0;
            if (p2_q != 5'd25) begin
              p2_q        <= p2_q + 5'd1;
              laneStart_q <= 1'b1;
              state_q     <= S_START;
            end else if (p1_q != 5'd25) begin
              p2_q        <= '0;
              p1_q        <= p1_q + 5'd1;
              laneStart_q <= 1'b1;
              state_q     <= S_START;
            end else begin
              p2_q <= '0;
              p1_q <= '0;
              if (orderLast) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                {r1_q, r2_q, r3_q} <= stepOrder(r1_q, r2_q, r3_q);
                state_q <= S_ORDER;
              end
            end
          end
        end
        S_ORDER: begin
          if (orderDistinct) begin
            laneStart_q <= 1'b1;
            state_q     <= S_START;
          end else begin
            {r1_q, r2_q, r3_q} <= stepOrder(r1_q, r2_q, r3_q);
          end
        end
        S_DONE: state_q <= S_DONE;
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Hit queue: scan pushes {order, p1, p2, p3+k}; consumer pops on valid&&ready.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fifoWr_q    <= '0;
      fifoRd_q    <= '0;
      fifoCount_q <= '0;
    end else begin
      if (scanPush) begin
        fifoMem_q[fifoWr_q] <= {r1_q, r2_q, r3_q, p1_q, p2_q, base_q + 5'(lane_q)};
        fifoWr_q            <= fifoWr_q + FW'(1);
      end
      if (hitPop) fifoRd_q <= fifoRd_q + FW'(1);
      if (scanPush && !hitPop)      fifoCount_q <= fifoCount_q + (FW + 1)'(1);
      else if (!scanPush && hitPop) fifoCount_q <= fifoCount_q - (FW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_bombe_search_ctrl.sv
// tb_bombe_search_ctrl: directed bench with echo-style lane models, a table of
// load/offset cases and hand-written sequences for hits, back-pressure and sweep order.
module tb_bombe_search_ctrl;

  localparam int TB_CRIB   = 5;
  localparam int TB_LANES  = 16;
  localparam int TB_DEPTH  = 16;
  localparam int TB_ROTORS = 3;
  localparam int TB_FIFO   = 8;
  localparam logic [8:0] ORD012 = 9'b000_001_010;
  localparam logic [8:0] ORD021 = 9'b000_010_001;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [4:0]              msgLetter = '0;
  logic                    msgValid = 1'b0;
  logic                    msgLast = 1'b0;
  logic [TB_CRIB*5-1:0]    crib = '0;
  logic [3:0]              cribOffset = '0;
  logic                    laneStart;
  logic [8:0]              laneOrder;
  logic [14:0]             lanePosBase;
  logic [4:0]              laneLetter;
  logic                    laneLetterValid;
  logic [TB_LANES*5-1:0]   laneResult = '0;
  logic                    laneResultValid = 1'b0;
  logic                    hitValid;
  logic                    hitReady = 1'b0;
  logic [8:0]              hitOrder;
  logic [14:0]             hitPos;
  logic                    busy, done, error;

  int total = 0;
  int bad = 0;
  int startCount = 0;
  int laneMatchCount = TB_LANES;
  logic [4:0]  msgData [32];
  logic [23:0] expHits [$];

  typedef struct {
    int numLetters;
    int offset;
    bit lastWithValid;
    bit expError;
    bit expStart;
    bit expDone;
  } vec_t;
  vec_t vecs [8];

  bombe_search_ctrl #(
    .CRIB_LEN(TB_CRIB), .NUM_LANES(TB_LANES), .MSG_DEPTH(TB_DEPTH),
    .NUM_ROTORS(TB_ROTORS), .HIT_FIFO_DEPTH(TB_FIFO)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .msg_letter_in(msgLetter), .msg_valid_in(msgValid), .msg_last_in(msgLast),
    .crib_in(crib), .crib_offset_in(cribOffset),
    .lane_start_out(laneStart), .lane_order_out(laneOrder),
    .lane_pos_base_out(lanePosBase), .lane_letter_out(laneLetter),
    .lane_letter_valid_out(laneLetterValid),
    .lane_result_in(laneResult), .lane_result_valid_in(laneResultValid),
    .hit_valid_out(hitValid), .hit_ready_in(hitReady),
    .hit_order_out(hitOrder), .hit_pos_out(hitPos),
    .busy_out(busy), .done_out(done), .error_out(error)
  );

  always #5 clk = ~clk;

  // Lane models: lanes below laneMatchCount echo the letter, others return letter+1.
  always @(posedge clk) begin
    laneResultValid <= 1'b0;
    if (laneLetterValid) begin
      laneResultValid <= 1'b1;
      for (int k = 0; k < TB_LANES; k++)
        laneResult[k*5 +: 5] <= (k < laneMatchCount) ? laneLetter :
                                ((laneLetter == 5'd25) ? 5'd0 : laneLetter + 5'd1);
    end
  end

  // Count every lane start pulse seen by the lanes.
  always @(posedge clk) begin
    if (laneStart) startCount <= startCount + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; msgValid = 1'b0; msgLast = 1'b0; hitReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int numLetters, input int offset, input bit lastWithValid);
    cribOffset = 4'(offset);
    for (int i = 0; i < numLetters; i++) begin
      @(negedge clk);
      msgLetter = msgData[i];
      msgValid  = 1'b1;
      msgLast   = lastWithValid && (i == numLetters - 1);
    end
    if (!lastWithValid || numLetters == 0) begin
      @(negedge clk);
      msgValid = 1'b0;
      msgLast  = 1'b1;
    end
    @(negedge clk);
    msgValid = 1'b0;
    msgLast  = 1'b0;
  endtask

  task automatic collectHits(input int want, input int budget, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < want && cyc < budget) begin
      if (hitValid && hitReady) begin
        checkOutput($sformatf("%s hit%0d", tag, got), 64'({hitOrder, hitPos}), 64'(expHits[got]));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " hit count"}, 64'(got), 64'(want));
  endtask

  initial begin
    int base;
    int found;
    int nPulses;
    int sweepBad;
    int hitSeen;
    logic [23:0] expSet;

    vecs[0] = '{8, 3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{14, 12, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{17, 11, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16, 12, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16, 11, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{4, 0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 32; i++) msgData[i] = 5'((i * 7 + 3) % 26);

    // Reset state straight out of power-up reset.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset outputs",
                64'({laneStart, laneOrder, lanePosBase, laneLetter, laneLetterValid,
                     hitValid, hitOrder, hitPos, busy, done, error}), 64'd0);
    rst = 1'b0;

    // Load length / crib offset table.
    for (int v = 0; v < 8; v++) begin
      doReset();
      base = startCount;
      applyStimulus(vecs[v].numLetters, vecs[v].offset, vecs[v].lastWithValid);
      repeat (20) @(negedge clk);
      checkOutput($sformatf("vec%0d error", v), 64'(error), 64'(vecs[v].expError));
      checkOutput($sformatf("vec%0d done", v), 64'(done), 64'(vecs[v].expDone));
      checkOutput($sformatf("vec%0d started", v), 64'(startCount > base), 64'(vecs[v].expStart));
      checkOutput($sformatf("vec%0d busy", v), 64'(busy), 64'(vecs[v].expStart));
    end

    // Reset asserted while letters are being fed.
    doReset();
    applyStimulus(8, 3, 1'b1);
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      if (laneLetterValid) found = 1;
      else @(negedge clk);
    end
    checkOutput("feed reached", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("feed reset outputs",
                64'({laneStart, laneOrder, lanePosBase, laneLetter, laneLetterValid,
                     hitValid, hitOrder, hitPos, busy, done, error}), 64'd0);
    rst = 1'b0;

    // All lanes echo; crib equals message letters 3..7; message ends with last+valid.
    doReset();
    laneMatchCount = TB_LANES;
    msgData[0] = 5'd7;  msgData[1] = 5'd4;  msgData[2] = 5'd11; msgData[3] = 5'd11;
    msgData[4] = 5'd14; msgData[5] = 5'd22; msgData[6] = 5'd14; msgData[7] = 5'd17;
    for (int j = 0; j < TB_CRIB; j++) crib[j*5 +: 5] = msgData[3 + j];
    expHits.delete();
    for (int p2 = 0; p2 < 2; p2++)
      for (int b = 0; b < 32; b += TB_LANES)
        for (int k = 0; k < TB_LANES; k++)
          if (b + k <= 25 && expHits.size() < 42)
            expHits.push_back({ORD012, 5'd0, 5'(p2), 5'(b + k)});
    applyStimulus(8, 3, 1'b1);
    hitReady = 1'b1;
    collectHits(42, 5000, "echo");

    // Twelve matching lanes against an eight-deep queue with the consumer stalled.
    doReset();
    laneMatchCount = 12;
    base = startCount;
    applyStimulus(8, 3, 1'b1);
    repeat (300) @(negedge clk);
    checkOutput("stall start count", 64'(startCount - base), 64'd1);
    checkOutput("stall busy", 64'(busy), 64'd1);
    checkOutput("stall hit valid", 64'(hitValid), 64'd1);
    expHits.delete();
    for (int k = 0; k < 12; k++) expHits.push_back({ORD012, 5'd0, 5'd0, 5'(k)});
    expHits.push_back({ORD012, 5'd0, 5'd0, 5'd16});
    hitReady = 1'b1;
    collectHits(13, 2000, "stall");

    // Sweep order across the first rotor-order boundary with a crib that never matches.
    doReset();
    laneMatchCount = TB_LANES;
    for (int i = 0; i < 5; i++) msgData[i] = 5'd0;
    for (int j = 0; j < TB_CRIB; j++) crib[j*5 +: 5] = 5'd1;
    hitReady = 1'b1;
    applyStimulus(5, 0, 1'b1);
    nPulses = 0;
    sweepBad = 0;
    hitSeen = 0;
    for (int c = 0; c < 60000 && nPulses < 1356; c++) begin
      if (hitValid) hitSeen++;
      if (laneStart) begin
        expSet = {(nPulses < 1352) ? ORD012 : ORD021,
                  5'((nPulses % 1352) / 52), 5'(((nPulses % 1352) / 2) % 26),
                  5'(((nPulses % 1352) % 2) * TB_LANES)};
        if ({laneOrder, lanePosBase} !== expSet) begin
          if (sweepBad == 0)
            $display("[TB] first sweep difference at pulse %0d: got %0h want %0h",
                     nPulses, {laneOrder, lanePosBase}, expSet);
          sweepBad++;
        end
        nPulses++;
      end
      @(negedge clk);
    end
    checkOutput("sweep pulses", 64'(nPulses), 64'd1356);
    checkOutput("sweep setting errors", 64'(sweepBad), 64'd0);
    checkOutput("sweep no hits", 64'(hitSeen), 64'd0);
    checkOutput("sweep busy", 64'(busy), 64'd1);
    checkOutput("sweep not done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
